// File: rtl/aes256_ctr_mode.sv
// AES-256 counter-mode stream engine. Runs an iterative one-round-per-cycle core
// that fills a small keystream FIFO; each accepted AXI-Stream beat is XORed with the FIFO head.
module aes256_ctr_mode #(
  parameter int KS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  config_register,
  output logic [31:0]  status_register,
  input  logic [255:0] input_key,
  input  logic [127:0] input_iv,
  output logic         s_axis_tready,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  input  logic [127:0] s_axis_tdata,
  input  logic         m_axis_tready,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  output logic [127:0] m_axis_tdata
);

  localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CW = $clog2(KS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(KS_DEPTH);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, GEN, WAIT} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes + ShiftRows are fused by reading row r of column c from column (c+r)%4.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic final_round);
    logic [127:0] res;
    logic [31:0]  col;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      col = '0;
      for (int r = 0; r < 4; r++)
        col[31-8*r -: 8] = sbox(st[127-8*(4*((c+r)%4)+r) -: 8]);
      res[127-32*c -: 32] = final_round ? col : mix_col(col);
    end
    return res ^ rk;
  endfunction

  state_t         state;
  logic           ready;
  logic [CW-1:0]  ks_count;
  logic [CW-1:0]  count_next;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [127:0]   ks_buf [KS_DEPTH];
  logic [31:0]    rk_file [60];
  logic [127:0]   ctr;
  logic [127:0]   aes_state;
  logic [3:0]     rnd;
  logic [5:0]     exp_idx;
  logic           load;
  logic           push;
  logic           pop;
  logic           busy;
  logic [5:0]     rk_base;
  logic [127:0]   round_key;
  logic [127:0]   round_out;
  logic [31:0]    prev_word;
  logic [31:0]    exp_word;
  logic [7:0]     rcon;
  logic           unused_cfg;

  assign load       = config_register[0];
  assign unused_cfg = ^config_register[31:1];
  assign busy       = (state == EXPAND) || (state == GEN);

  assign s_axis_tready   = ready && (ks_count != '0) && (!m_axis_tvalid || m_axis_tready);
  assign status_register = {26'd0, 4'(ks_count), busy, ready};

  assign push = (state == GEN) && (rnd == 4'd14);
  assign pop  = s_axis_tvalid && s_axis_tready;

  assign rk_base   = {rnd, 2'b00};
  assign round_key = {rk_file[rk_base], rk_file[rk_base + 6'd1],
                      rk_file[rk_base + 6'd2], rk_file[rk_base + 6'd3]};
  assign round_out = aes_round(aes_state, round_key, rnd == 4'd14);

  // Key schedule word i depends on w[i-1] and w[i-8]; every 8th word gets RotWord/SubWord/Rcon.
  always_comb begin
    prev_word = rk_file[exp_idx - 6'd1];
    case (exp_idx[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
    if (exp_idx[2:0] == 3'd0)
      exp_word = rk_file[exp_idx - 6'd8] ^ sub_word({prev_word[23:0], prev_word[31:24]})
                 ^ {rcon, 24'h0};
    else if (exp_idx[2:0] == 3'd4)
      exp_word = rk_file[exp_idx - 6'd8] ^ sub_word(prev_word);
    else
      exp_word = rk_file[exp_idx - 6'd8] ^ prev_word;
  end

  always_comb begin
    count_next = ks_count;
    if (push && !pop)
      count_next = ks_count + 1'b1;
    else if (!push && pop)
      count_next = ks_count - 1'b1;
  end

  // Round-key file and keystream storage are always overwritten before being read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++)
        rk_file[i] <= input_key[255-32*i -: 32];
    end else if (state == EXPAND) begin
      rk_file[exp_idx] <= exp_word;
    end
    if (push && !load)
      ks_buf[wr_ptr] <= round_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ready         <= 1'b0;
      ks_count      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      ctr           <= '0;
      aes_state     <= '0;
      rnd           <= '0;
      exp_idx       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (load) begin
      state         <= EXPAND;
      ready         <= 1'b0;
      ks_count      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      ctr           <= input_iv;
      rnd           <= '0;
      exp_idx       <= 6'd8;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (pop) begin
        m_axis_tdata  <= s_axis_tdata ^ ks_buf[rd_ptr];
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      ks_count <= count_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;

      case (state)
        IDLE: ;
        EXPAND: begin
          if (exp_idx == 6'd59) begin
            state <= GEN;
            ready <= 1'b1;
            rnd   <= '0;
          end else begin
            exp_idx <= exp_idx + 6'd1;
          end
        end
        GEN: begin
          if (rnd == 4'd0) begin
            aes_state <= ctr ^ round_key;
            rnd       <= 4'd1;
          end else begin
            aes_state <= round_out;
            if (rnd == 4'd14) begin
              rnd <= '0;
              ctr <= ctr + 128'd1;
              if (count_next == FULL)
                state <= WAIT;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
        end
        WAIT: begin
          if (ks_count < FULL)
            state <= GEN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_ctr_mode.sv
// Self-checking bench for aes256_ctr_mode: NIST CTR vectors, streaming against a
// byte-level AES reference model, backpressure, counter wrap and mid-stream reload.
`timescale 1ns/1ps
module tb_aes256_ctr_mode;

  localparam int KS_DEPTH = 4;
  localparam logic [255:0] NIST_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] NIST_IV = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  logic         clk;
  logic         rst;
  logic [31:0]  config_register;
  logic [31:0]  status_register;
  logic [255:0] input_key;
  logic [127:0] input_iv;
  logic         s_axis_tready;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic [127:0] s_axis_tdata;
  logic         m_axis_tready;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic [127:0] m_axis_tdata;

  aes256_ctr_mode #(.KS_DEPTH(KS_DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .config_register (config_register),
    .status_register (status_register),
    .input_key       (input_key),
    .input_iv        (input_iv),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tdata    (s_axis_tdata),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tdata    (m_axis_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    logic [127:0] pt;
    logic         last;
    logic [127:0] ct;
  } vec_t;

  beat_t        exp_q[$];
  vec_t         vecs[4];
  int           n_checks;
  int           n_errors;
  int           n_out;
  logic [7:0]   sbox_tab [256];
  logic [7:0]   rk_bytes [240];
  logic [127:0] ctr_model;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map, independent of any table.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_set_key(input logic [255:0] key);
    logic [7:0] t [4];
    logic [7:0] rc;
    logic [7:0] tmp;
    for (int i = 0; i < 32; i++) rk_bytes[i] = key[255-8*i -: 8];
    rc = 8'h01;
    for (int i = 32; i < 240; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = rk_bytes[i-4+j];
      if (i % 32 == 0) begin
        tmp  = t[0];
        t[0] = sbox_tab[t[1]] ^ rc;
        t[1] = sbox_tab[t[2]];
        t[2] = sbox_tab[t[3]];
        t[3] = sbox_tab[tmp];
        rc   = gmul(rc, 8'h02);
      end else if (i % 32 == 16) begin
        for (int j = 0; j < 4; j++) t[j] = sbox_tab[t[j]];
      end
      for (int j = 0; j < 4; j++) rk_bytes[i+j] = rk_bytes[i-32+j] ^ t[j];
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] blk);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ rk_bytes[i];
    for (int r = 1; r <= 14; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sbox_tab[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 14) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_bytes[16*r+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic load_key(input logic [255:0] key, input logic [127:0] iv, input int hold);
    input_key       = key;
    input_iv        = iv;
    config_register = 32'h0000_0001;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    config_register = 32'h0;
    model_set_key(key);
    ctr_model = iv;
  endtask

  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    while (!status_register[0] && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("ready reached", 128'(status_register[0]), 128'(1));
  endtask

  task automatic wait_full(input int budget, output int cycles);
    cycles = 0;
    while (status_register[5:2] != 4'(KS_DEPTH) && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("buffer full", 128'(status_register[5:2]), 128'(KS_DEPTH));
  endtask

  // Offers one beat, waits (bounded) for acceptance and queues the model's expected output.
  task automatic apply_stimulus(input logic [127:0] data, input logic last, output int stall);
    beat_t b;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    stall = 0;
    @(negedge clk);
    while (!s_axis_tready && stall < 1000) begin
      stall++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      check_output("accept timeout", 128'(0), 128'(1));
    end else begin
      b.data = data ^ aes_model(ctr_model);
      b.last = last;
      exp_q.push_back(b);
      ctr_model = ctr_model + 128'd1;
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_output("scoreboard empty", 128'(exp_q.size()), 128'(0));
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (m_axis_tvalid && m_axis_tready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_output("unexpected output", m_axis_tdata, 128'(0));
      end else begin
        e = exp_q.pop_front();
        check_output("stream tdata", m_axis_tdata, e.data);
        check_output("stream tlast", 128'(m_axis_tlast), 128'(e.last));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cycles;
    int stall;
    int total_stall;
    int out_before;
    beat_t b;
    logic [127:0] held_exp;
    logic [127:0] d;

    n_checks = 0;
    n_errors = 0;
    n_out    = 0;
    vecs[0] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a, last: 1'b0,
                ct: 128'h601ec313775789a5b7a7f504bbf3d228};
    vecs[1] = '{pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51, last: 1'b0,
                ct: 128'hf443e3ca4d62b59aca84e990cacaf5c5};
    vecs[2] = '{pt: 128'h30c81c46a35ce411e5fbc1191a0a52ef, last: 1'b0,
                ct: 128'h2b0930daa23de94ce87017ba2d84988d};
    vecs[3] = '{pt: 128'hf69f2445df4f9b17ad2b417be66c3710, last: 1'b1,
                ct: 128'hdfc9c58db67aada613c2dd08457941a6};

    rst = 1'b1;
    config_register = '0;
    input_key = '0;
    input_iv = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    init_sbox();

    repeat (3) @(posedge clk);
    #1;
    check_output("reset status", 128'(status_register), 128'(0));
    check_output("reset s_tready", 128'(s_axis_tready), 128'(0));
    check_output("reset m_tvalid", 128'(m_axis_tvalid), 128'(0));
    check_output("reset m_tlast", 128'(m_axis_tlast), 128'(0));
    check_output("reset m_tdata", m_axis_tdata, 128'(0));
    rst = 1'b0;

    // Idle before any LOAD: an offered beat must not be taken.
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check_output("idle s_tready", 128'(s_axis_tready), 128'(0));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;

    // Key schedule and buffer fill timing.
    load_key(NIST_KEY, NIST_IV, 1);
    check_output("expand status", 128'(status_register), 128'(32'h2));
    wait_ready(200, cycles);
    check_output("expand cycles", 128'(cycles), 128'(52));
    wait_full(200, cycles);
    check_output("fill time in range", 128'(cycles >= 58 && cycles <= 64), 128'(1));
    check_output("full status", 128'(status_register), 128'({26'd0, 4'(KS_DEPTH), 2'b01}));

    // NIST vectors back-to-back, checking one-cycle latency on every beat.
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = vecs[i].pt;
      s_axis_tlast  = vecs[i].last;
      @(negedge clk);
      check_output($sformatf("nist tready %0d", i), 128'(s_axis_tready), 128'(1));
      b.data = vecs[i].ct;
      b.last = vecs[i].last;
      exp_q.push_back(b);
      ctr_model = ctr_model + 128'd1;
      @(posedge clk);
      #1;
      check_output($sformatf("nist valid %0d", i), 128'(m_axis_tvalid), 128'(1));
      check_output($sformatf("nist tdata %0d", i), m_axis_tdata, vecs[i].ct);
      check_output($sformatf("nist tlast %0d", i), 128'(m_axis_tlast), 128'(vecs[i].last));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drain();

    // Sustained stream at one beat per 15 cycles starting from a full buffer.
    wait_full(200, cycles);
    total_stall = 0;
    out_before  = n_out;
    for (int n = 0; n < 200; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(d, (n % 50) == 49, stall);
      total_stall += stall;
      repeat (14) @(posedge clk);
      #1;
    end
    drain();
    check_output("sustained stalls", 128'(total_stall), 128'(0));
    check_output("sustained outputs", 128'(n_out - out_before), 128'(200));

    // Backpressure: one beat held while the sink stalls for 20 cycles.
    m_axis_tready = 1'b0;
    apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, stall);
    held_exp = exp_q[0].data;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("hold tvalid", 128'(m_axis_tvalid), 128'(1));
      check_output("hold tdata", m_axis_tdata, held_exp);
      check_output("hold s_tready", 128'(s_axis_tready), 128'(0));
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++)
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, i == 3, stall);
    drain();

    // Counter wrap from all-ones to zero.
    load_key(NIST_KEY, '1, 1);
    wait_ready(200, cycles);
    wait_full(200, cycles);
    apply_stimulus('0, 1'b0, stall);
    apply_stimulus('0, 1'b1, stall);
    drain();

    // Mid-stream LOAD (held three cycles) drops the pending beat and restarts the counter.
    load_key(NIST_KEY, NIST_IV, 1);
    wait_ready(200, cycles);
    wait_full(200, cycles);
    m_axis_tready = 1'b0;
    apply_stimulus(vecs[1].pt, 1'b0, stall);
    check_output("pending before load", 128'(m_axis_tvalid), 128'(1));
    load_key(NIST_KEY, NIST_IV, 3);
    check_output("tvalid after load", 128'(m_axis_tvalid), 128'(0));
    check_output("status after load", 128'(status_register), 128'(32'h2));
    exp_q.delete();
    m_axis_tready = 1'b1;
    wait_ready(200, cycles);
    wait_full(200, cycles);
    apply_stimulus(vecs[0].pt, 1'b0, stall);
    check_output("restart tdata", m_axis_tdata, vecs[0].ct);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
